// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic SZ_WORD = 1'b0;
    localparam logic SZ_BYTE = 1'b1;

    function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [7:0] b);
        return {word[31:8], b};
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Formats the read buffer into the response word: full word, or a zero/sign-extended low byte.
module lsu_extend (
    input  logic [31:0] rdbuf,
    input  logic        is_byte,
    input  logic        is_signed,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = rdbuf;
        if (is_byte) begin
            rdata = is_signed ? {{24{rdbuf[7]}}, rdbuf[7:0]} : {24'd0, rdbuf[7:0]};
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store controller in front of a byte-addressed word memory;
// byte stores are done as read-modify-write of the containing word.
//
// state | meaning
// IDLE  | ready for a request; checks and latches it on accept
// READ  | memory word captured into rdbuf
// WRITE | mem_we asserted, word (or merged word) written on the closing edge
// RESP  | one-cycle response pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 301
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wd,
    input  logic [31:0]           mem_rd
);

    localparam logic [ADDR_WIDTH:0] LAST_BYTE = (ADDR_WIDTH+1)'(MEM_BYTES - 1);

    lsu_state_t state, state_nx;

    logic              write_q;
    logic              byte_q;
    logic              signed_q;
    logic              err_q;
    logic [31:0]       rdbuf;
    logic [31:0]       ext_data;
    logic              accept;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic [ADDR_WIDTH:0] last_addr;

    assign accept       = req_valid && (state == IDLE);
    // One extra bit so addr+3 near the top of the address space cannot wrap to a small value.
    assign last_addr    = {1'b0, req_addr} + (ADDR_WIDTH+1)'(3);
    assign misaligned   = (req_byte == SZ_WORD) && (req_addr[1:0] != 2'b00);
    assign out_of_range = last_addr > LAST_BYTE;
    assign req_err      = misaligned || out_of_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_nx = RESP;
                    end else if (!req_write || (req_byte == SZ_BYTE)) begin
                        state_nx = READ;
                    end else begin
                        state_nx = WRITE;
                    end
                end
            end
            READ:    state_nx = write_q ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // mem_wd holds the store data from accept; a byte store keeps its byte in mem_wd[7:0]
    // and merges the upper bytes read back during READ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_wd   <= '0;
            rdbuf    <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr <= req_addr;
                mem_wd   <= req_wdata;
                write_q  <= req_write;
                byte_q   <= req_byte;
                signed_q <= req_signed;
                err_q    <= req_err;
            end
            if (state == READ) begin
                rdbuf <= mem_rd;
                if (write_q) begin
                    mem_wd <= merge_byte(mem_rd, mem_wd[7:0]);
                end
            end
        end
    end

    lsu_extend u_extend (
        .rdbuf     (rdbuf),
        .is_byte   (byte_q == SZ_BYTE),
        .is_signed (signed_q),
        .rdata     (ext_data)
    );

    assign req_ready = (state == IDLE);
    assign mem_we    = (state == WRITE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !write_q) ? ext_data : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory behind it.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [7:0]  mem [0:300];
    logic        init_mem;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rsp_count = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .MEM_BYTES(301)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 301; i++) mem[i] <= 8'(i);
        end else if (mem_we && mem_addr <= 32'd297) begin
            mem[mem_addr]     <= mem_wd[7:0];
            mem[mem_addr + 1] <= mem_wd[15:8];
            mem[mem_addr + 2] <= mem_wd[23:16];
            mem[mem_addr + 3] <= mem_wd[31:24];
        end
    end

    always_comb begin
        mem_rd = 32'd0;
        if (mem_addr <= 32'd297)
            mem_rd = {mem[mem_addr + 3], mem[mem_addr + 2], mem[mem_addr + 1], mem[mem_addr]};
    end

    always @(posedge clk) if (rsp_valid) rsp_count++;

    function automatic logic [31:0] word_at(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE and watch six cycles after the accept edge.
    task automatic do_req(input logic wr, input logic bt, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int rsp_cyc, output logic [7:0] we_mask);
        check_val("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_byte   = bt;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rdata   = 32'd0;
        err     = 1'b0;
        rsp_cyc = 0;
        we_mask = 8'd0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (mem_we) we_mask[c] = 1'b1;
            if (rsp_valid) begin
                rsp_cyc = c;
                rdata   = rsp_rdata;
                err     = rsp_err;
            end
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          rc;
    logic [7:0]  wm;
    int          cnt0;
    logic [7:0]  ready_pat;
    logic [7:0]  rsp_pat;
    logic [31:0] b2b_data [2];
    int          b2b_n;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        init_mem = 1'b1;
        @(posedge clk);
        #1;
        init_mem = 1'b0;
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_val("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check_val("rst_mem_addr",  mem_addr, 32'd0);
        check_val("rst_mem_wd",    mem_wd,   32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // word store then word load
        do_req(1'b1, 1'b0, 1'b0, 32'd32, 32'hDEADBEEF, rd, er, rc, wm);
        check_val("wst_rsp_cyc", rc, 32'd2);
        check_val("wst_err", {31'd0, er}, 32'd0);
        check_val("wst_we_mask", {24'd0, wm}, 32'h02);
        check_val("wst_mem", word_at(32), 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 1'b0, 32'd32, 32'd0, rd, er, rc, wm);
        check_val("wld_rsp_cyc", rc, 32'd2);
        check_val("wld_rdata", rd, 32'hDEADBEEF);
        check_val("wld_we_mask", {24'd0, wm}, 32'h00);

        // byte store (upper wdata bytes must be ignored)
        do_req(1'b1, 1'b1, 1'b0, 32'd33, 32'h1234565A, rd, er, rc, wm);
        check_val("bst_rsp_cyc", rc, 32'd3);
        check_val("bst_we_mask", {24'd0, wm}, 32'h04);
        check_val("bst_rdata", rd, 32'd0);
        do_req(1'b0, 1'b0, 1'b0, 32'd32, 32'd0, rd, er, rc, wm);
        check_val("bst_readback", rd, 32'hDEAD5AEF);

        // byte loads
        do_req(1'b0, 1'b1, 1'b0, 32'd35, 32'd0, rd, er, rc, wm);
        check_val("bld_unsigned", rd, 32'h000000DE);
        check_val("bld_rsp_cyc", rc, 32'd2);
        do_req(1'b0, 1'b1, 1'b1, 32'd35, 32'd0, rd, er, rc, wm);
        check_val("bld_signed_neg", rd, 32'hFFFFFFDE);
        do_req(1'b0, 1'b1, 1'b1, 32'd33, 32'd0, rd, er, rc, wm);
        check_val("bld_signed_pos", rd, 32'h0000005A);

        // errors and range boundary
        do_req(1'b0, 1'b0, 1'b0, 32'd34, 32'd0, rd, er, rc, wm);
        check_val("mis_rsp_cyc", rc, 32'd1);
        check_val("mis_err", {31'd0, er}, 32'd1);
        check_val("mis_rdata", rd, 32'd0);
        check_val("mis_we_mask", {24'd0, wm}, 32'h00);
        do_req(1'b1, 1'b0, 1'b0, 32'd298, 32'hCAFEF00D, rd, er, rc, wm);
        check_val("oor_st_err", {31'd0, er}, 32'd1);
        check_val("oor_st_we_mask", {24'd0, wm}, 32'h00);
        check_val("oor_st_mem", word_at(297), 32'h2C2B2A29);
        do_req(1'b0, 1'b0, 1'b0, 32'd296, 32'd0, rd, er, rc, wm);
        check_val("last_word_err", {31'd0, er}, 32'd0);
        check_val("last_word_rdata", rd, 32'h2B2A2928);
        do_req(1'b0, 1'b1, 1'b0, 32'd297, 32'd0, rd, er, rc, wm);
        check_val("edge_byte_err", {31'd0, er}, 32'd0);
        check_val("edge_byte_rdata", rd, 32'h00000029);
        do_req(1'b0, 1'b1, 1'b0, 32'd298, 32'd0, rd, er, rc, wm);
        check_val("oor_byte_err", {31'd0, er}, 32'd1);
        check_val("oor_byte_cyc", rc, 32'd1);

        // reset during WRITE of a word store
        check_val("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 32'd40; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_val("rst_mid_we_before", {31'd0, mem_we}, 32'd1);
        cnt0 = rsp_count;
        #2 reset = 1'b1;
        #1;
        check_val("rst_mid_we_fall", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_mid_no_rsp", rsp_count - cnt0, 32'd0);
        check_val("rst_mid_mem", word_at(40), 32'h2B2A2928);
        check_val("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);

        // back-to-back loads with req_valid held high
        ready_pat = 8'd0;
        rsp_pat   = 8'd0;
        b2b_n     = 0;
        b2b_data[0] = 32'd0;
        b2b_data[1] = 32'd0;
        cnt0 = rsp_count;
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 32'd32;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            ready_pat[c] = req_ready;
            rsp_pat[c]   = rsp_valid;
            if (rsp_valid && b2b_n < 2) begin
                b2b_data[b2b_n] = rsp_rdata;
                b2b_n++;
            end
            if (c == 1) req_addr = 32'd36;
            if (c == 6) req_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val("b2b_ready_pat", {24'd0, ready_pat}, 32'h48);
        check_val("b2b_rsp_pat", {24'd0, rsp_pat}, 32'h24);
        check_val("b2b_rsp_count", rsp_count - cnt0, 32'd2);
        check_val("b2b_data0", b2b_data[0], 32'hDEAD5AEF);
        check_val("b2b_data1", b2b_data[1], 32'h27262524);
        check_val("b2b_idle_after", {31'd0, req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store controller that sits directly upstream of the byte-addressed data `Memory`. It drives that memory's `ADDR`/`WE`/`WD` ports and reads its `RD` port. It accepts one word or byte access per handshake from the datapath and performs byte stores as read-modify-write. It returns registered, optionally sign-extended load data with an error flag.

## Interface
- `ADDR_WIDTH`, default 32: address width; matches the memory.
- `MEM_BYTES`, default 301: number of implemented memory bytes; used for the range check.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_signed` in 1: byte load sign-extends when 1; ignored otherwise.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data; byte store uses `[7:0]`.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 1: access rejected; valid with `rsp_valid`.
- `rsp_rdata` out 32: load result; valid with `rsp_valid`; 0 for stores and errors.
- `mem_addr` out ADDR_WIDTH: to memory `ADDR`.
- `mem_we` out 1: to memory `WE`.
- `mem_wd` out 32: to memory `WD`.
- `mem_rd` in 32: from memory `RD`; combinational, little-endian (byte at `ADDR` = `[7:0]`).

## Operation
**States:** IDLE, READ, WRITE, RESP.

**IDLE**
- `req_ready`=1.
- On `req_valid`, latch addr, wdata, write, byte and signed into registers.
- Run the checks:
  - misaligned = word access with `addr[1:0]`≠0;
  - out-of-range = `addr+3` > `MEM_BYTES-1`, computed in ADDR_WIDTH+1 bits so it cannot wrap.
- Next state:
  - any error → RESP with `err`=1;
  - load or byte store → READ;
  - word store → WRITE.

**READ**
- `mem_addr`=latched addr; capture `mem_rd` into `rdbuf`.
- Next state: byte store → WRITE; load → RESP.

**WRITE**
- `mem_we`=1; `mem_addr`=latched addr.
- `mem_wd`: word store = wdata; byte store = {`rdbuf[31:8]`, `wdata[7:0]`}. The memory always writes 4 bytes, so the upper 3 bytes are rewritten unchanged.
- → RESP.

**RESP**
- `rsp_valid`=1 for exactly one cycle; → IDLE.
- `rsp_rdata`:
  - word load = `rdbuf`;
  - byte load = zero- or sign-extended `rdbuf[7:0]` per `req_signed`;
  - store or error = 0.

**Port behaviour**
- `mem_we` is decoded from the state only; it is 0 outside WRITE.
- `mem_addr` and `mem_wd` are driven from registers, so they are stable through each state.
- Requests arriving outside IDLE are not accepted. The requester must hold `req_*` until `req_ready`.
- An errored access never asserts `mem_we`.

## Timing
All counts are relative to the accept edge k (`req_valid`&`req_ready` sampled).

| Access | Cycle k+1 | Cycle k+2 | Cycle k+3 | Memory written at |
|---|---|---|---|---|
| Load (word/byte) | READ | RESP, `rsp_valid` | IDLE, `req_ready`=1 | — |
| Word store | WRITE | RESP | IDLE | edge k+2 |
| Byte store | READ | WRITE | RESP | edge k+3 |
| Error | RESP, `rsp_err`=1 | IDLE | — | never |

**Throughput:** a back-to-back request can be accepted at the edge that ends RESP+1, i.e. the first IDLE cycle.

**Reset values:**
- state=IDLE, `req_ready`=1;
- `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0;
- `mem_we`=0, `mem_addr`=0, `mem_wd`=0;
- `rdbuf`=0.

**Reset mid-operation:** the FSM returns to IDLE asynchronously and `mem_we` falls immediately. An unfinished WRITE leaves memory unchanged, because the memory writes only on the edge. No response is issued for the aborted request.

## Structure
- **Shared package `lsu_pkg`:**
  - state encoding: IDLE=2'd0, READ=2'd1, WRITE=2'd2, RESP=2'd3;
  - size encoding constants: SZ_WORD=0, SZ_BYTE=1.
- **Sub-module `lsu_extend`:** combinational; inputs `rdbuf`, `byte`, `signed`; output is the formatted `rsp_rdata` value. Instantiated once in `load_store_unit`.

## Test plan
1. **Word store then load:** store `32'hDEADBEEF` to addr 32, then load word from 32.
   - Store: `mem_we` high in cycle k+1 only; `rsp_valid` at k+2, `rsp_err`=0.
   - Load: `rsp_rdata`=`32'hDEADBEEF` at k+2.
2. **Byte store:** memory[32..35]=`EF BE AD DE`; store byte `8'h5A` to addr 33; then load word from 32.
   - Store: `mem_we` high at k+2 only, `rsp_valid` at k+3.
   - Load: `rsp_rdata`=`32'hDEAD5AEF`.
3. **Byte loads from addr 35 holding 8'hDE:**
   - unsigned load → `rsp_rdata`=`32'h000000DE`;
   - signed load → `rsp_rdata`=`32'hFFFFFFDE`.
4. **Errors:**
   - word load at addr 34 → `rsp_valid` & `rsp_err` at k+1, `rsp_rdata`=0, no memory access;
   - word store at addr 298 → error, memory unchanged, `mem_we` never high.
5. **Reset mid-store:** assert `reset` asynchronously during the WRITE cycle of a word store of `32'h12345678` to addr 40.
   - `mem_we` falls before the next edge;
   - `rsp_valid` never pulses;
   - memory[40..43] keeps its old value;
   - after reset, `req_ready`=1.
6. **Back-to-back handshake:** hold `req_valid` high continuously across two loads.
   - second accept occurs at the first IDLE cycle after RESP;
   - `req_ready`=0 in READ, WRITE and RESP;
   - exactly two `rsp_valid` pulses.
